// File: rtl/sram_bus_controller.sv
// sram_bus_controller
//   Converts the one-hot SRAM block selects from the block decoder and the 68k bus
//   strobes into registered SRAM control signals with a wait-stated DTACK.
//   One SRAM transaction is run per assertion of AS_L.
//
// Parameters
//   WAIT_STATES  extra ACCESS cycles before DTACK (0..15)
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset_H      in   synchronous active-high reset
//   Block0_H..3  in   one-hot block selects from the block decoder
//   AS_L         in   68k address strobe
//   UDS_L/LDS_L  in   68k upper/lower data strobes
//   RW           in   1 = read, 0 = write
//   SRamCE_L     out  per-block chip enables (bit n = block n)
//   SRamUB_L     out  upper byte lane enable
//   SRamLB_L     out  lower byte lane enable
//   SRamOE_L     out  output enable, reads only
//   SRamWE_L     out  write enable, writes only
//   Dtack_L      out  data transfer acknowledge
//   DecodeErr_H  out  one-cycle pulse when several selects are seen with AS_L low
module sram_bus_controller #(
  parameter int WAIT_STATES = 1
) (
  input  logic       Clk,
  input  logic       Reset_H,
  input  logic       Block0_H,
  input  logic       Block1_H,
  input  logic       Block2_H,
  input  logic       Block3_H,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       RW,
  output logic [3:0] SRamCE_L,
  output logic       SRamUB_L,
  output logic       SRamLB_L,
  output logic       SRamOE_L,
  output logic       SRamWE_L,
  output logic       Dtack_L,
  output logic       DecodeErr_H
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

  state_t     state;
  logic [3:0] sel;
  logic [3:0] cnt;
  logic       rd_lat;
  logic       err_armed;
  logic       one_sel;
  logic       multi_sel;
  logic       start;

  function automatic logic more_than_one(input logic [3:0] s);
    return (s & (s - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] s);
    if (s[3])      return 2'd3;
    else if (s[2]) return 2'd2;
    else if (s[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [3:0] ce_mask(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign sel       = {Block3_H, Block2_H, Block1_H, Block0_H};
  assign multi_sel = more_than_one(sel);
  assign one_sel   = (sel != 4'd0) && !multi_sel;
  // A write whose strobes arrive late just waits here in IDLE until they show up.
  assign start     = !AS_L && one_sel && (!UDS_L || !LDS_L);

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      err_armed   <= 1'b1;
      SRamCE_L    <= 4'b1111;
      SRamUB_L    <= 1'b1;
      SRamLB_L    <= 1'b1;
      SRamOE_L    <= 1'b1;
      SRamWE_L    <= 1'b1;
      Dtack_L     <= 1'b1;
      DecodeErr_H <= 1'b0;
    end else begin
      DecodeErr_H <= 1'b0;
      // The decode error may fire again only once the bus cycle has ended.
      if (AS_L) err_armed <= 1'b1;

      if (AS_L && state != IDLE) begin
        // Abort from SETUP/ACCESS, or normal end of ACK: release everything.
        state    <= IDLE;
        SRamCE_L <= 4'b1111;
        SRamUB_L <= 1'b1;
        SRamLB_L <= 1'b1;
        SRamOE_L <= 1'b1;
        SRamWE_L <= 1'b1;
        Dtack_L  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= SETUP;
              cnt      <= 4'(WAIT_STATES);
              rd_lat   <= RW;
              SRamCE_L <= ce_mask(sel_index(sel));
              SRamUB_L <= UDS_L;
              SRamLB_L <= LDS_L;
              SRamOE_L <= ~RW;
              SRamWE_L <= 1'b1;
              Dtack_L  <= 1'b1;
            end else if (!AS_L && multi_sel && err_armed) begin
              DecodeErr_H <= 1'b1;
              err_armed   <= 1'b0;
            end
          end
          SETUP: begin
            state    <= ACCESS;
            SRamWE_L <= rd_lat;
          end
          ACCESS: begin
            if (cnt == 4'd0) begin
              // WE rising here is what commits a write; CE/UB/LB stay put.
              state    <= ACK;
              SRamWE_L <= 1'b1;
              Dtack_L  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ACK: begin
            // Hold everything until the 68k drops AS_L.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_controller.sv
// tb_sram_bus_controller
//   Drives three controllers (WAIT_STATES = 0, 1, 5) from the same bus stimulus and
//   compares every cycle of their outputs against a transaction-level model that
//   tracks, per controller, whether an access is live and how many cycles have
//   elapsed since its start edge.
module tb_sram_bus_controller;

  localparam int WS [3] = '{0, 1, 5};

  logic       Clk = 1'b0;
  logic       Reset_H, AS_L, UDS_L, LDS_L, RW;
  logic [3:0] blk;
  logic [3:0] ce  [3];
  logic       ub  [3];
  logic       lb  [3];
  logic       oe  [3];
  logic       we  [3];
  logic       dt  [3];
  logic       err [3];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_bus_controller #(.WAIT_STATES(WS[g])) u_dut (
      .Clk(Clk), .Reset_H(Reset_H),
      .Block0_H(blk[0]), .Block1_H(blk[1]), .Block2_H(blk[2]), .Block3_H(blk[3]),
      .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
      .SRamCE_L(ce[g]), .SRamUB_L(ub[g]), .SRamLB_L(lb[g]), .SRamOE_L(oe[g]),
      .SRamWE_L(we[g]), .Dtack_L(dt[g]), .DecodeErr_H(err[g])
    );
  end

  // Model state per controller
  bit         m_act   [3];
  int         m_d     [3];
  logic [1:0] m_blk   [3];
  bit         m_rd    [3];
  bit         m_ub    [3];
  bit         m_lb    [3];
  bit         m_err   [3];
  bit         m_armed [3];

  typedef logic [2:0][9:0] exp_t;
  exp_t  expq [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string tname    = "init";

  // {ce, ub, lb, oe, we, dtack, err}
  function automatic logic [9:0] exp_vec(input int i);
    logic [3:0] c;
    logic       w, d;
    if (!m_act[i]) return {4'b1111, 5'b11111, m_err[i]};
    c = 4'b1111;
    c[m_blk[i]] = 1'b0;
    // Write strobe is low only during the WAIT_STATES+1 access cycles.
    w = (!m_rd[i] && m_d[i] >= 1 && m_d[i] <= WS[i] + 1) ? 1'b0 : 1'b1;
    d = (m_d[i] >= WS[i] + 2) ? 1'b0 : 1'b1;
    return {c, m_ub[i], m_lb[i], ~m_rd[i], w, d, 1'b0};
  endfunction

  function automatic logic [9:0] obs_vec(input int i);
    return {ce[i], ub[i], lb[i], oe[i], we[i], dt[i], err[i]};
  endfunction

  task automatic model_update();
    int   nsel;
    exp_t e;
    nsel = $countones(blk);
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 1'b0;
      if (Reset_H) begin
        m_act[i]   = 1'b0;
        m_armed[i] = 1'b1;
      end else begin
        if (m_act[i]) begin
          if (AS_L) m_act[i] = 1'b0;
          else      m_d[i]   = m_d[i] + 1;
        end else if (!AS_L && nsel == 1 && (!UDS_L || !LDS_L)) begin
          m_act[i] = 1'b1;
          m_d[i]   = 0;
          for (int k = 0; k < 4; k++) if (blk[k]) m_blk[i] = 2'(k);
          m_rd[i]  = RW;
          m_ub[i]  = UDS_L;
          m_lb[i]  = LDS_L;
        end else if (!AS_L && nsel > 1 && m_armed[i]) begin
          m_err[i]   = 1'b1;
          m_armed[i] = 1'b0;
        end
        if (AS_L) m_armed[i] = 1'b1;
      end
      e[i] = exp_vec(i);
    end
    expq.push_back(e);
  endtask

  // Apply one cycle of bus inputs, record the expected outputs after the next edge.
  task automatic step(input bit rst, input bit as, input logic [3:0] b,
                      input bit uds, input bit lds, input bit rw);
    Reset_H = rst;
    AS_L    = as;
    blk     = b;
    UDS_L   = uds;
    LDS_L   = lds;
    RW      = rw;
    model_update();
    @(posedge Clk);
    #1;
  endtask

  // late: AS low with strobes still high; low: AS low with strobes; gap: AS high.
  task automatic txn(input logic [3:0] b, input bit uds, input bit lds, input bit rw,
                     input int late, input int low, input int gap);
    for (int c = 0; c < late; c++) step(1'b0, 1'b0, b, 1'b1, 1'b1, rw);
    for (int c = 0; c < low; c++)  step(1'b0, 1'b0, b, uds, lds, rw);
    for (int c = 0; c < gap; c++)  step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cyc++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_vec(i) !== e[i]) begin
          n_fail++;
          $display("FAIL %s W=%0d cycle=%0d actual {ce,ub,lb,oe,we,dtack,err}=%b required %b",
                   tname, WS[i], cyc, obs_vec(i), e[i]);
        end
      end
    end
  end

  initial begin
    logic [3:0] b;
    bit         uds, lds, rw, rst;
    int         r, low, gap;

    tname = "reset";
    step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);

    tname = "read_blk2";
    txn(4'b0100, 1'b0, 1'b0, 1'b1, 0, 10, 1);

    tname = "write_blk0_late_lds";
    txn(4'b0001, 1'b1, 1'b0, 1'b0, 1, 10, 1);

    tname = "abort_in_access";
    txn(4'b0010, 1'b0, 1'b0, 1'b0, 0, 4, 2);

    tname = "decode_err";
    txn(4'b1010, 1'b0, 1'b0, 1'b1, 0, 4, 1);
    txn(4'b1010, 1'b0, 1'b0, 1'b0, 0, 3, 2);

    tname = "back_to_back_blk3";
    txn(4'b1000, 1'b0, 1'b0, 1'b1, 0, 4, 1);
    txn(4'b1000, 1'b0, 1'b1, 1'b0, 0, 4, 2);

    tname = "reset_mid_access";
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);

    tname = "random";
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       b = 4'b0001 << $urandom_range(0, 3);
      else if (r == 7) b = 4'b0000;
      else             b = 4'b0011 << $urandom_range(0, 2);
      uds = 1'($urandom_range(0, 1));
      lds = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      low = int'($urandom_range(1, 12));
      gap = int'($urandom_range(1, 3));
      for (int c = 0; c < low; c++) begin
        if (c > 0 && $urandom_range(0, 3) == 0) begin
          b   = 4'($urandom_range(0, 15));
          uds = 1'($urandom_range(0, 1));
          lds = 1'($urandom_range(0, 1));
          rw  = 1'($urandom_range(0, 1));
        end
        rst = ($urandom_range(0, 39) == 0);
        step(rst, 1'b0, b, uds, lds, rw);
      end
      for (int c = 0; c < gap; c++)
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    end

    tname = "drain";
    for (int t = 0; t < 20 && expq.size() > 0; t++) @(negedge Clk);
    if (expq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual %0d pending required 0", expq.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
